// File: rtl/cnt_wrap_tracker.sv
// Wrap tracker for a WIDTH-bit up/down load counter. It keeps a wrap epoch,
// and queues one {dir, epoch} record per genuine wrap for a valid/ready consumer.
module cnt_wrap_tracker #(
    parameter int WIDTH   = 4,
    parameter int EPOCH_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         count,
    input  logic                     down,
    input  logic                     load_en,
    input  logic                     clr,
    output logic [EPOCH_W-1:0]       epoch,
    output logic [EPOCH_W+WIDTH-1:0] ext_count,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_dir,
    output logic [EPOCH_W-1:0]       evt_epoch,
    output logic                     evt_ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0]   MAX_C       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ZERO_C      = {WIDTH{1'b0}};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE_C = EPOCH_W'(1);
    localparam logic [AW:0]        OCC_FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]        OCC_ONE_C   = (AW+1)'(1);
    localparam logic [AW:0]        OCC_ZERO_C  = (AW+1)'(0);
    localparam logic [AW-1:0]      PTR_ONE_C   = AW'(1);

    logic [WIDTH-1:0]             prev_count_r;
    logic                         prev_down_r;
    logic                         prev_load_r;
    logic                         prev_vld_r;
    logic [EPOCH_W-1:0]           epoch_r;
    logic [AW-1:0]                wr_ptr_r;
    logic [AW-1:0]                rd_ptr_r;
    logic [AW:0]                  occ_r;
    logic                         valid_r;
    logic                         ovf_r;
    logic [DEPTH-1:0][EPOCH_W:0]  mem_r;

    logic                         wrap_up_s;
    logic                         wrap_dn_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         full_s;
    logic                         wr_en_s;
    logic                         drop_s;
    logic [EPOCH_W-1:0]           epoch_nxt_s;
    logic [AW:0]                  occ_nxt_s;

    // Wrap detection against history, plus FIFO handshake and next-state decode
    always_comb begin
        wrap_up_s   = 1'b0;
        wrap_dn_s   = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        full_s      = 1'b0;
        wr_en_s     = 1'b0;
        drop_s      = 1'b0;
        epoch_nxt_s = epoch_r;
        occ_nxt_s   = occ_r;

        // A load that lands on 0 or MAX is never treated as a wrap.
        if (prev_vld_r && !prev_load_r) begin
            wrap_up_s = !prev_down_r && (prev_count_r == MAX_C)  && (count == ZERO_C);
            wrap_dn_s =  prev_down_r && (prev_count_r == ZERO_C) && (count == MAX_C);
        end else begin
            wrap_up_s = 1'b0;
            wrap_dn_s = 1'b0;
        end

        push_s  = wrap_up_s || wrap_dn_s;
        pop_s   = (occ_r != OCC_ZERO_C) && evt_ready;
        full_s  = (occ_r == OCC_FULL_C);
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;

        case ({wrap_up_s, wrap_dn_s})
            2'b10:   epoch_nxt_s = epoch_r + EPOCH_ONE_C;
            2'b01:   epoch_nxt_s = epoch_r - EPOCH_ONE_C;
            default: epoch_nxt_s = epoch_r;
        endcase

        case ({wr_en_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_ONE_C;
            2'b01:   occ_nxt_s = occ_r - OCC_ONE_C;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // History of the counter controls applied at the previous edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_count_r <= ZERO_C;
            prev_down_r  <= 1'b0;
            prev_load_r  <= 1'b0;
            prev_vld_r   <= 1'b0;
        end else begin
            prev_count_r <= count;
            prev_down_r  <= down;
            prev_load_r  <= load_en;
            prev_vld_r   <= !clr;
        end
    end

    // Epoch, FIFO pointers/occupancy and sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            epoch_r  <= {EPOCH_W{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= OCC_ZERO_C;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (clr) begin
            epoch_r  <= {EPOCH_W{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= OCC_ZERO_C;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            epoch_r  <= epoch_nxt_s;
            wr_ptr_r <= wr_en_s ? (wr_ptr_r + PTR_ONE_C) : wr_ptr_r;
            rd_ptr_r <= pop_s   ? (rd_ptr_r + PTR_ONE_C) : rd_ptr_r;
            occ_r    <= occ_nxt_s;
            valid_r  <= (occ_nxt_s != OCC_ZERO_C);
            ovf_r    <= ovf_r || drop_s;
        end
    end

    // Event record storage; cleared so an empty FIFO presents a zero head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_r <= '0;
        end else if (clr) begin
            mem_r <= '0;
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {wrap_dn_s, epoch_nxt_s};
        end
    end

    assign epoch     = epoch_r;
    assign ext_count = {epoch_r, count};
    assign evt_valid = valid_r;
    assign evt_dir   = mem_r[rd_ptr_r][EPOCH_W];
    assign evt_epoch = mem_r[rd_ptr_r][EPOCH_W-1:0];
    assign evt_ovf   = ovf_r;

endmodule

// File: tb/tb_cnt_wrap_tracker.sv
// Bench for cnt_wrap_tracker: an emulated upstream counter drives the DUT,
// and a queue-based reference model built from the wrap rules checks every cycle.
module tb_cnt_wrap_tracker;
    localparam int WIDTH   = 4;
    localparam int EPOCH_W = 8;
    localparam int DEPTH   = 4;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic [3:0]  count     = 4'd0;
    logic        down      = 1'b0;
    logic        load_en   = 1'b0;
    logic        clr       = 1'b0;
    logic        evt_ready = 1'b0;
    logic [7:0]  epoch;
    logic [11:0] ext_count;
    logic        evt_valid;
    logic        evt_dir;
    logic [7:0]  evt_epoch;
    logic        evt_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_epoch = 0;
    bit m_ovf   = 1'b0;
    int m_q[$];
    bit h_vld   = 1'b0;
    int h_count = 0;
    bit h_down  = 1'b0;
    bit h_load  = 1'b0;

    cnt_wrap_tracker #(.WIDTH(WIDTH), .EPOCH_W(EPOCH_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .count     (count),
        .down      (down),
        .load_en   (load_en),
        .clr       (clr),
        .epoch     (epoch),
        .ext_count (ext_count),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_dir   (evt_dir),
        .evt_epoch (evt_epoch),
        .evt_ovf   (evt_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record encoding in the model queue: dir * 256 + epoch
    task automatic model_edge();
        bit wu;
        bit wd;
        if (clr) begin
            m_epoch = 0;
            m_q.delete();
            m_ovf = 1'b0;
            h_vld = 1'b0;
        end else begin
            wu = h_vld && !h_load && !h_down && (h_count == 15) && (count == 4'd0);
            wd = h_vld && !h_load &&  h_down && (h_count == 0)  && (count == 4'd15);
            if (m_q.size() > 0 && evt_ready)
                void'(m_q.pop_front());
            if (wu) m_epoch = (m_epoch + 1) % 256;
            if (wd) m_epoch = (m_epoch + 255) % 256;
            if (wu || wd) begin
                if (m_q.size() < DEPTH) m_q.push_back((wd ? 256 : 0) + m_epoch);
                else m_ovf = 1'b1;
            end
            h_vld = 1'b1;
        end
        h_count = int'(count);
        h_down  = down;
        h_load  = load_en;
    endtask

    task automatic model_reset();
        m_epoch = 0;
        m_ovf   = 1'b0;
        m_q.delete();
        h_vld   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [11:0] exp_ext;
        exp_ext = {8'(m_epoch), count};
        check_val({tag, ".epoch"}, 32'(epoch), 32'(m_epoch));
        check_val({tag, ".ext_count"}, 32'(ext_count), 32'(exp_ext));
        check_val({tag, ".evt_valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
        check_val({tag, ".evt_ovf"}, 32'(evt_ovf), 32'(m_ovf));
        if (m_q.size() > 0) begin
            check_val({tag, ".evt_dir"}, 32'(evt_dir), 32'(m_q[0] / 256));
            check_val({tag, ".evt_epoch"}, 32'(evt_epoch), 32'(m_q[0] % 256));
        end
    endtask

    // One clock of upstream counter plus consumer activity, then a full check
    task automatic step(input logic d, input logic ld, input logic [3:0] lv,
                        input logic rdy, input logic c, input string tag);
        down      = d;
        load_en   = ld;
        evt_ready = rdy;
        clr       = c;
        @(posedge clk);
        model_edge();
        #1;
        if (ld)     count = lv;
        else if (d) count = count - 4'd1;
        else        count = count + 4'd1;
        #1;
        check_outputs(tag);
    endtask

    // Count up to 15, then step onto 0 and through the edge that sees the wrap
    task automatic up_wrap(input logic rdy_at_wrap, input logic clr_at_wrap, input string tag);
        for (int i = 0; i < 20 && count != 4'd15; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, tag);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, tag);
        step(1'b0, 1'b0, 4'd0, rdy_at_wrap, clr_at_wrap, tag);
    endtask

    // Asynchronous reset between edges; outputs checked while reset is held
    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        check_val({tag, ".rst_dir"}, 32'(evt_dir), 32'd0);
        check_val({tag, ".rst_epoch"}, 32'(evt_epoch), 32'd0);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        logic       rd;
        logic [3:0] lv;
        int         saved_epoch;

        #3;
        check_outputs("reset");
        #9;
        rstn = 1'b1;

        // 1: up-wrap
        up_wrap(1'b0, 1'b0, "t1");
        check_val("t1.epoch_one", 32'(epoch), 32'h01);
        check_val("t1.dir_up", 32'(evt_dir), 32'd0);
        check_val("t1.evt_epoch", 32'(evt_epoch), 32'h01);
        check_val("t1.ext_hi", 32'(ext_count[11:4]), 32'h01);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "t1.drain");

        // 2: down-wrap straight after reset
        do_reset("t2.rst");
        step(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "t2");
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "t2");
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "t2");
        check_val("t2.epoch_ff", 32'(epoch), 32'hFF);
        check_val("t2.dir_dn", 32'(evt_dir), 32'd1);
        check_val("t2.evt_epoch", 32'(evt_epoch), 32'hFF);

        // 3: loads landing on 0 or 15 are not wraps
        step(1'b1, 1'b1, 4'd15, 1'b1, 1'b0, "t3");
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "t3");
        step(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, "t3");
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "t3");
        check_val("t3.no_event", 32'(evt_valid), 32'd0);
        check_val("t3.epoch_kept", 32'(epoch), 32'hFF);

        // 4: overflow with the consumer stalled
        do_reset("t4.rst");
        for (int i = 0; i < 5; i++) up_wrap(1'b0, 1'b0, "t4");
        check_val("t4.ovf", 32'(evt_ovf), 32'd1);
        check_val("t4.epoch5", 32'(epoch), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check_val("t4.order", 32'(evt_epoch), 32'(i + 1));
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "t4.drain");
        end
        check_val("t4.empty", 32'(evt_valid), 32'd0);

        // 5: full FIFO with a pop in the wrap cycle
        do_reset("t5.rst");
        for (int i = 0; i < 4; i++) up_wrap(1'b0, 1'b0, "t5");
        up_wrap(1'b1, 1'b0, "t5");
        check_val("t5.no_ovf", 32'(evt_ovf), 32'd0);
        check_val("t5.epoch5", 32'(epoch), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check_val("t5.occ", 32'(evt_valid), 32'd1);
            check_val("t5.order", 32'(evt_epoch), 32'(i + 2));
            step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "t5.drain");
        end
        check_val("t5.empty", 32'(evt_valid), 32'd0);

        // 6: clr in a wrap cycle, then a mid-stream reset
        do_reset("t6.rst");
        up_wrap(1'b0, 1'b0, "t6");
        up_wrap(1'b0, 1'b0, "t6");
        check_val("t6.epoch2", 32'(epoch), 32'd2);
        up_wrap(1'b0, 1'b1, "t6.clr");
        check_val("t6.clr_empty", 32'(evt_valid), 32'd0);
        check_val("t6.clr_epoch", 32'(epoch), 32'd0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "t6.after");
        check_val("t6.no_late_evt", 32'(evt_valid), 32'd0);
        up_wrap(1'b0, 1'b0, "t6");
        do_reset("t6.midrst");
        check_val("t6.rst_valid", 32'(evt_valid), 32'd0);

        // Randomized traffic against the model
        rd = 1'b0;
        saved_epoch = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(31) == 0) rd = ~rd;
            case ($urandom_range(3))
                0:       lv = 4'd0;
                1:       lv = 4'd15;
                default: lv = 4'($urandom_range(15));
            endcase
            step(rd, ($urandom_range(11) == 0), lv,
                 (i < 400) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0),
                 ($urandom_range(99) == 0), "rnd");
            if ($urandom_range(299) == 0) do_reset("rnd.rst");
            if (epoch != 8'(saved_epoch)) saved_epoch = int'(epoch);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
